seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector. It is the next generation of the lab's fixed-pattern single-bit sequence-detector FSM.
- Samples one serial bit per enabled clock and compares the last PAT_W bits against a pattern register. That register is loadable at runtime.
- Supports overlapping and non-overlapping detection modes, selected at runtime.
- Keeps a saturating match counter. Sits behind a serial input stage; y feeds downstream control logic.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1001, reset value of the pattern register; width PAT_W. MSB is compared against the oldest bit.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- x  input  1  serial data bit; sampled only when en=1.
- en  input  1  sample enable; when 0, all state holds and y is 0 next cycle.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- load  input  1  load pat_in into the pattern register.
- pat_in  input  PAT_W  new pattern value.
- y  output  1  registered match pulse.
- match_cnt  output  CNT_W  number of matches since reset or load; saturating.
- cnt_sat  output  1  high while match_cnt is all ones.

Behaviour:
- Clocking and reset: single clock domain. rst is synchronous and active-low.
- Reset state (edge with rst=0):
  - hist = 0, fill = 0.
  - pat = PATTERN.
  - y = 0, match_cnt = 0, cnt_sat = 0.
  - Reset has priority over load and en, including in the middle of a partial match; all partial progress is lost.
- Internal state:
  - hist: PAT_W-bit shift register of sampled bits, newest bit at LSB.
  - fill: counts 0..PAT_W, giving the number of valid bits in hist; width $clog2(PAT_W+1).
- Load (rst=1, load=1):
  - pat <= pat_in; hist <= 0; fill <= 0; y <= 0; match_cnt <= 0.
  - load has priority over en; the x presented that cycle is discarded.
- Sample (rst=1, load=0, en=1):
  - nh = {hist[PAT_W-2:0], x}.
  - hit = (nh == pat) && (fill >= PAT_W-1), i.e. at least PAT_W valid bits including the current one.
  - hist <= nh.
  - y <= hit.
- Effect of hit on fill:
  - hit=0: fill <= min(fill+1, PAT_W).
  - hit=1 and overlap=1: fill <= PAT_W; history is retained so the tail can begin the next match.
  - hit=1 and overlap=0: fill <= 0; the next match needs PAT_W fresh bits.
- match_cnt increments on hit, except when it is already all ones, where it holds. cnt_sat = &match_cnt, registered together with match_cnt.
- Idle (rst=1, load=0, en=0): hist, fill and match_cnt hold; y <= 0.
- Latency: y rises exactly one clock after the edge that samples the completing bit, and stays high for one cycle per match. Back-to-back matches give consecutive high cycles; this is only possible with overlap=1 and a periodic pattern, e.g. all-ones.
- overlap may change on any cycle. It takes effect on the sample in which it is presented.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then release rst=1 with en=1 and overlap=1. Drive x = 1,0,0,1,0,0,1 on consecutive cycles. Required: y pulses one cycle after the 4th and 7th bits; match_cnt=2.
2. Same stream with overlap=0. Required: y pulses only after the 4th bit; match_cnt=1.
3. Drive x = 1,0,0; hold en=0 for 3 cycles with x=0; then drive x=1. Required: y stays 0 while en=0 and pulses one cycle after the final 1.
4. Drive x = 1,0,0, then assert rst=0 for one cycle, then drive x=1. Required: no y pulse; fill restarts and match_cnt=0. After reset, driving 1,0,0,1 gives one pulse.
5. Drive load=1, pat_in=4'b1111, overlap=1, then six 1s. Required: y high on 3 consecutive cycles starting one clock after the 4th 1; match_cnt=3.
6. Parameter CNT_W=2: drive 5 matches. Required: match_cnt reaches 3 and holds; cnt_sat=1 from the cycle match_cnt becomes 3; y still pulses on every match.

Source files
------------

// File: rtl/seq_detect_param_if.sv
// Serial detector bus: stimulus side (master) drives bits and pattern loads,
// detector side (slave) returns the match pulse and counter.
interface seq_detect_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             x;
    logic             en;
    logic             overlap;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output x, en, overlap, load, pat_in,
        input  y, match_cnt, cnt_sat
    );

    modport slave (
        input  x, en, overlap, load, pat_in,
        output y, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern,
// overlap/non-overlap modes and a saturating match counter.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
    parameter int               CNT_W   = 8
) (
    input logic               clk,
    input logic               rst,
    seq_detect_param_if.slave bus
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MIN  = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  hist, pat, nh;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              y_q, sat_q, hit;

    always_comb begin
        nh  = {hist[PAT_W-2:0], bus.x};
        // The current bit counts as valid, so PAT_W-1 stored bits suffice.
        hit = (nh == pat) && (fill >= FILL_MIN);
        cnt_nxt = cnt + CNT_W'(hit && !(&cnt));
        if (hit)
            fill_nxt = bus.overlap ? FILL_FULL : '0;
        else if (fill == FILL_FULL)
            fill_nxt = fill;
        else
            fill_nxt = fill + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist  <= '0;
            fill  <= '0;
            pat   <= PATTERN;
            y_q   <= 1'b0;
            cnt   <= '0;
            sat_q <= 1'b0;
        end else if (bus.load) begin
            pat   <= bus.pat_in;
            hist  <= '0;
            fill  <= '0;
            y_q   <= 1'b0;
            cnt   <= '0;
            sat_q <= 1'b0;
        end else if (bus.en) begin
            hist  <= nh;
            fill  <= fill_nxt;
            y_q   <= hit;
            cnt   <= cnt_nxt;
            sat_q <= &cnt_nxt;
        end else begin
            y_q   <= 1'b0;
        end
    end

    assign bus.y         = y_q;
    assign bus.match_cnt = cnt;
    assign bus.cnt_sat   = sat_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed-vector bench for seq_detect_param: default 8-bit counter instance
// driven from a table, plus a 2-bit counter instance for saturation.
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) bus_a ();
    seq_detect_param_if #(.PAT_W(4), .CNT_W(2)) bus_b ();

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1001), .CNT_W(8))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1001), .CNT_W(2))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    typedef struct {
        logic       r, e, xx, ov, ld;
        logic [3:0] pi;
        logic       ey;
        logic [7:0] ec;
        logic       es;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, e, xx, ov, ld, input logic [3:0] pi,
                       input logic ey, input logic [7:0] ec, input logic es);
        vec_t v;
        v.r = r; v.e = e; v.xx = xx; v.ov = ov; v.ld = ld; v.pi = pi;
        v.ey = ey; v.ec = ec; v.es = es;
        vecs.push_back(v);
    endtask

    // sample: rst=1,en=1,load=0 with bit b and overlap o
    task automatic s(input logic b, input logic o, input logic ey, input logic [7:0] ec);
        add(1, 1, b, o, 0, 4'h0, ey, ec, 0);
    endtask

    task automatic rst_row();
        add(0, 1, 1, 1, 1, 4'hF, 0, 0, 0);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        bus_a.x = 0; bus_a.en = 0; bus_a.overlap = 0; bus_a.load = 0; bus_a.pat_in = '0;
        bus_b.x = 0; bus_b.en = 0; bus_b.overlap = 0; bus_b.load = 0; bus_b.pat_in = '0;

        // 1: overlapping, 1001001 -> pulses after bits 4 and 7
        rst_row();
        s(1,1,0,0); s(0,1,0,0); s(0,1,0,0); s(1,1,1,1);
        s(0,1,0,1); s(0,1,0,1); s(1,1,1,2);
        // 2: non-overlapping, same stream -> only one pulse
        rst_row();
        s(1,0,0,0); s(0,0,0,0); s(0,0,0,0); s(1,0,1,1);
        s(0,0,0,1); s(0,0,0,1); s(1,0,0,1);
        // 3: enable gaps hold partial progress
        rst_row();
        s(1,1,0,0); s(0,1,0,0); s(0,1,0,0);
        add(1,0,0,1,0,4'h0, 0,0,0); add(1,0,0,1,0,4'h0, 0,0,0); add(1,0,0,1,0,4'h0, 0,0,0);
        s(1,1,1,1);
        add(1,0,1,1,0,4'h0, 0,1,0);
        // 4: reset mid-match discards progress
        rst_row();
        s(1,1,0,0); s(0,1,0,0); s(0,1,0,0);
        rst_row();
        s(1,1,0,0); s(0,1,0,0); s(0,1,0,0); s(1,1,1,1);
        // 5: load all-ones (x discarded, count cleared), back-to-back pulses
        add(1,1,1,1,1,4'b1111, 0,0,0);
        s(1,1,0,0); s(1,1,0,0); s(1,1,0,0);
        s(1,1,1,1); s(1,1,1,2); s(1,1,1,3);
        add(1,0,1,1,0,4'h0, 0,3,0);
        // load has priority over en: a mid-stream load loses history
        s(1,1,1,4);
        add(1,1,1,1,1,4'b0110, 0,0,0);
        s(1,1,0,0); s(1,1,0,0); s(0,1,0,0); s(0,1,0,0);
        s(1,1,0,0); s(1,1,0,0); s(0,1,1,1);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst_a = vecs[i].r; bus_a.en = vecs[i].e; bus_a.x = vecs[i].xx;
            bus_a.overlap = vecs[i].ov; bus_a.load = vecs[i].ld; bus_a.pat_in = vecs[i].pi;
            @(posedge clk); #1;
            chk("y", i, 32'(bus_a.y), 32'(vecs[i].ey));
            chk("match_cnt", i, 32'(bus_a.match_cnt), 32'(vecs[i].ec));
            chk("cnt_sat", i, 32'(bus_a.cnt_sat), 32'(vecs[i].es));
            @(negedge clk);
        end

        // 6: 2-bit counter saturation, stream 1,(0,0,1)x5 with overlap
        begin
            logic [1:0] exp_cnt [5];
            logic       exp_sat [5];
            logic [15:0] stream;
            exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 3; exp_cnt[3] = 3; exp_cnt[4] = 3;
            exp_sat[0] = 0; exp_sat[1] = 0; exp_sat[2] = 1; exp_sat[3] = 1; exp_sat[4] = 1;
            stream = 16'b1001001001001001;
            rst_b = 1'b0;
            @(posedge clk); #1;
            chk("b_rst_cnt", 0, 32'(bus_b.match_cnt), 0);
            chk("b_rst_sat", 0, 32'(bus_b.cnt_sat), 0);
            @(negedge clk);
            rst_b = 1'b1; bus_b.en = 1'b1; bus_b.overlap = 1'b1;
            for (int k = 0; k < 16; k++) begin
                bus_b.x = stream[15-k];
                @(posedge clk); #1;
                if (k % 3 == 0 && k > 0) begin
                    chk("b_y", k, 32'(bus_b.y), 1);
                    chk("b_cnt", k, 32'(bus_b.match_cnt), 32'(exp_cnt[k/3-1]));
                    chk("b_sat", k, 32'(bus_b.cnt_sat), 32'(exp_sat[k/3-1]));
                end else begin
                    chk("b_y_idle", k, 32'(bus_b.y), 0);
                end
                @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
